// File: rtl/vpu_multi_delay_cntr.sv
// Multi-channel programmable delay counter: each channel pulses done_o N cycles after an accepted start.
// Latency: done_o in cycle T+N for a start accepted in cycle T (count 0 behaves as 1); reject_o is same-cycle.
// Backpressure: none; a start while running is rejected, or reloads the count when VPU_MULTI_DELAY_CNTR_RETRIGGER_EN is defined.
module vpu_multi_delay_cntr #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         start_i,
  input  logic [NUM_CH*CNT_W-1:0]   count_i,
  input  logic [NUM_CH-1:0]         abort_i,
  output logic [NUM_CH-1:0]         busy_o,
  output logic [NUM_CH-1:0]         done_o,
  output logic [NUM_CH-1:0]         reject_o,
  output logic [NUM_CH*CNT_W-1:0]   remain_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      logic [0:0]       state_q;
      logic [CNT_W-1:0] remain_q;
      logic [CNT_W-1:0] count_in;
      logic [CNT_W-1:0] load_val;
      logic             is_run;
      logic             last;
      logic             accept;
      logic             busy_start;
      logic             reload;

      assign count_in   = count_i[g*CNT_W +: CNT_W];
      // A zero count still needs one cycle to produce its done pulse.
      assign load_val   = (count_in == '0) ? CNT_W'(1) : count_in;
      assign is_run     = (state_q == ST_RUN);
      assign last       = is_run && (remain_q == CNT_W'(1));
      // Abort outranks start: a start in an abort cycle is neither accepted nor rejected.
      assign accept     = start_i[g] && !abort_i[g] && (!is_run || last);
      assign busy_start = start_i[g] && !abort_i[g] && is_run && !last;

`ifdef VPU_MULTI_DELAY_CNTR_RETRIGGER_EN
      assign reload      = accept || busy_start;
      assign reject_o[g] = 1'b0;
`else
      assign reload      = accept;
      assign reject_o[g] = busy_start;
`endif

      // Channel state: abort, then (re)load, then count down to idle.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state_q  <= ST_IDLE;
          remain_q <= '0;
        end else if (abort_i[g]) begin
          state_q  <= ST_IDLE;
          remain_q <= '0;
        end else if (reload) begin
          state_q  <= ST_RUN;
          remain_q <= load_val;
        end else if (last) begin
          state_q  <= ST_IDLE;
          remain_q <= '0;
        end else if (is_run) begin
          remain_q <= remain_q - CNT_W'(1);
        end
      end

      assign busy_o[g]                   = is_run;
      assign done_o[g]                   = last && !abort_i[g];
      assign remain_o[g*CNT_W +: CNT_W]  = remain_q;
    end
  endgenerate

endmodule
